pudding_cfg_chain: RTL
======================

# pudding_cfg_chain

Parametrised configuration scan chain for the PUDDING tile: serial-in/serial-out shift register with a shadow state register, multi-lane shifting, frame-length checking on commit, and a self-timed unload mode for readback. It sits between the pad-level control inputs (datum/shift/transfer/dir) and the analog/digital configuration bits it drives through `state_o`, replacing the fixed 128-bit single-lane chain.

## Interface

**Parameters**
- `WIDTH`, 128: chain and state length in bits.
- `LANES`, 1: bits shifted per shift cycle. Must divide `WIDTH`. Define N = WIDTH/LANES shifts per frame.
- `OBS_BITS`, 8: width of the observation tap on the chain MSBs. Must satisfy OBS_BITS ≤ WIDTH.

**Ports**
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `din`, in, LANES: serial data in; enters the chain LSBs.
- `shift`, in, 1: shift chain by LANES.
- `transfer`, in, 1: chain↔state transfer.
- `dir`, in, 1: with transfer, 1 = commit (chain→state), 0 = capture (state→chain).
- `stream`, in, 1: with capture, start auto-unload.
- `clr_err`, in, 1: clear sticky `err`.
- `dout`, out, LANES: chain[WIDTH-1 -: LANES], the serial out.
- `dout_valid`, out, 1: high on each UNLOAD cycle.
- `obs`, out, OBS_BITS: chain[WIDTH-1 -: OBS_BITS].
- `state_o`, out, WIDTH: shadow state.
- `busy`, out, 1: high in UNLOAD.
- `updated`, out, 1: one-cycle pulse after an accepted commit.
- `err`, out, 1: sticky frame-length error.

## Operation

- Registers: `chain[WIDTH]`, `state[WIDTH]`, `cnt` (clog2(N+2) bits, saturates at N+1), `ucnt` (unload counter), FSM {IDLE, UNLOAD}, `err`, `updated`.
- Reset: chain, state, cnt, ucnt, err and updated are cleared. FSM goes to IDLE, so `busy`, `dout_valid`, `dout`, `obs` and `state_o` are all 0.
- IDLE priority: transfer, then shift, then hold.
  - **Commit** (transfer & dir):
    - If cnt == N: state ← chain, updated pulses next cycle, cnt ← 0.
    - Otherwise: state is unchanged, err ← 1, cnt ← 0.
    - chain is unchanged in both cases.
  - **Capture** (transfer & !dir): chain ← state, cnt ← 0.
    - If `stream` is also high: FSM → UNLOAD, ucnt ← 0.
  - **Shift** (shift only): chain ← {chain[WIDTH-1-LANES:0], din}; cnt ← min(cnt+1, N+1).
- UNLOAD:
  - Each cycle: chain shifts by LANES with zero fill (`din` is ignored), ucnt increments, and `dout_valid` = 1.
  - On the cycle where ucnt == N-1, the shift still happens and the FSM → IDLE. UNLOAD therefore lasts exactly N cycles.
  - `shift`, `transfer` and `stream` are ignored; cnt stays 0.
- `clr_err`: err ← 0. If a failed commit occurs in the same cycle, set wins and err ends up 1.
- Lane ordering: lane LANES-1 of `din` is the most recent-but-highest bit. After N shifts, the first-shifted `din` occupies chain[WIDTH-1 -: LANES].

## Timing

- All outputs are registered or direct register slices; there are no combinational input→output paths.
- Shift: the new chain value, and therefore `dout`/`obs`, is visible 1 cycle after the shift edge.
- Commit: `state_o` changes 1 cycle after the transfer edge, and `updated` is high in that same cycle, for exactly 1 cycle.
- Capture + stream:
  - `busy` and `dout_valid` rise 1 cycle after the transfer edge.
  - The first `dout_valid` cycle presents the captured state[WIDTH-1 -: LANES].
  - Frame k (k = 0..N-1) is on `dout` in valid cycle k.
  - `busy` is high for exactly N cycles.
- Back-to-back commit after exactly N shifts is allowed with no idle gap.
- `rst` asserted mid-UNLOAD takes effect at that edge: IDLE next cycle, all outputs 0.

## Test plan

- **Reset:** assert `rst` for 1 cycle after random activity → all outputs 0, `busy` = 0, `err` = 0.
- **Exact-frame commit** (WIDTH=128, LANES=1): shift in 128 bits 0xDEADBEEF_… pattern, then commit → `state_o` equals pattern, `updated` = 1 for one cycle, `err` = 0.
- **Short and long frames:**
  - Shift 127 bits, commit → `state_o` unchanged, `err` = 1.
  - `clr_err`, shift 130 bits, commit → `err` = 1 again, `state_o` unchanged.
- **Priority:** transfer & shift in the same cycle → only the transfer takes effect, cnt = 0. Commit with simultaneous `clr_err` → `err` = 1.
- **Streamed readback** (WIDTH=16, LANES=4): load state 0xA5C3 via 4 shifts + commit, then capture with `stream` → `dout_valid` for 4 cycles, `dout` = 0xA, 0x5, 0xC, 0x3, `busy` drops after the 4th. Shift/transfer pulses during UNLOAD are ignored.
- **Reset mid-UNLOAD:** assert `rst` at the 2nd UNLOAD cycle → next cycle `busy` = 0, chain = 0, state = 0.

Source files
------------

// File: rtl/pudding_cfg_chain.sv
// PUDDING tile configuration scan chain: multi-lane shift register with shadow
// state, frame-length checked commit, and self-timed streamed readback.
module pudding_cfg_chain #(
    parameter int WIDTH    = 128,
    parameter int LANES    = 1,
    parameter int OBS_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [LANES-1:0]    din,
    input  logic                shift,
    input  logic                transfer,
    input  logic                dir,
    input  logic                stream,
    input  logic                clr_err,
    output logic [LANES-1:0]    dout,
    output logic                dout_valid,
    output logic [OBS_BITS-1:0] obs,
    output logic [WIDTH-1:0]    state_o,
    output logic                busy,
    output logic                updated,
    output logic                err
);

    localparam int N  = WIDTH / LANES;
    localparam int CW = $clog2(N + 2);
    localparam int UW = (N > 1) ? $clog2(N) : 1;

    localparam logic [CW-1:0] CNT_FULL = CW'(N);
    localparam logic [CW-1:0] CNT_SAT  = CW'(N + 1);
    localparam logic [UW-1:0] U_LAST   = UW'(N - 1);

    typedef enum logic {
        IDLE,
        UNLOAD
    } fsm_e;

    fsm_e             fsm_q, fsm_d;
    logic [WIDTH-1:0] chain_q, chain_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [UW-1:0]    ucnt_q, ucnt_d;
    logic             err_q, err_d;
    logic             upd_q, upd_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] shift_din;
    logic [WIDTH-1:0] shift_zero;
    logic             frame_fail;

    // Shift-based form stays legal when LANES == WIDTH (no empty slice).
    always_comb begin
        shift_zero             = chain_q << LANES;
        shift_din              = shift_zero;
        shift_din[LANES-1:0]   = din;
    end

    always_comb begin
        fsm_d      = fsm_q;
        chain_d    = chain_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        ucnt_d     = ucnt_q;
        busy_d     = busy_q;
        upd_d      = 1'b0;
        frame_fail = 1'b0;

        case (fsm_q)
            IDLE: begin
                if (transfer) begin
                    cnt_d = '0;
                    if (dir) begin
                        if (cnt_q == CNT_FULL) begin
                            state_d = chain_q;
                            upd_d   = 1'b1;
                        end else begin
                            frame_fail = 1'b1;
                        end
                    end else begin
                        chain_d = state_q;
                        if (stream) begin
                            fsm_d  = UNLOAD;
                            busy_d = 1'b1;
                            ucnt_d = '0;
                        end
                    end
                end else if (shift) begin
                    chain_d = shift_din;
                    if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            UNLOAD: begin
                chain_d = shift_zero;
                ucnt_d  = ucnt_q + 1'b1;
                cnt_d   = '0;
                if (ucnt_q == U_LAST) begin
                    fsm_d  = IDLE;
                    busy_d = 1'b0;
                end
            end
            default: begin
                fsm_d  = IDLE;
                busy_d = 1'b0;
            end
        endcase

        // A failed commit in the same cycle as clr_err leaves err set.
        err_d = (err_q & ~clr_err) | frame_fail;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            chain_q <= '0;
            state_q <= '0;
            cnt_q   <= '0;
            ucnt_q  <= '0;
            err_q   <= 1'b0;
            upd_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            chain_q <= chain_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ucnt_q  <= ucnt_d;
            err_q   <= err_d;
            upd_q   <= upd_d;
            busy_q  <= busy_d;
        end
    end

    assign dout       = chain_q[WIDTH-1 -: LANES];
    assign obs        = chain_q[WIDTH-1 -: OBS_BITS];
    assign state_o    = state_q;
    assign busy       = busy_q;
    assign dout_valid = busy_q;
    assign updated    = upd_q;
    assign err        = err_q;

endmodule
